issue_slot_steer: RTL and testbench
===================================

Name: issue_slot_steer

Overview:
- Issue-stage register between fetch and the parallel-hazard check / dual decoders.
- Accepts an in-order instruction pair from fetch and steers each instruction into the branch/int slot or the load-store/int slot.
- Drives the slot instructions, their PCs and the priority bit (which slot is older).
- Splits structurally conflicting pairs, and replays the deferred instruction when the downstream hazard check stalls.

Parameters:
- XLEN, 32, instruction and PC width.
- NOP_INSTR, 32'h0000_0000, encoding placed in an empty slot; must match the hazard check's NOP.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- fetch_valid_i  in  1  pair on fetch_instr0_i/fetch_instr1_i is valid
- fetch_instr0_i  in  XLEN  older instruction of pair
- fetch_instr1_i  in  XLEN  younger instruction of pair
- fetch_pc_i  in  XLEN  PC of instr0; instr1 PC = fetch_pc_i+4
- fetch_ready_o  out  1  pair accepted this cycle when valid&&ready
- flush_i  in  1  branch redirect; kills everything held
- stall_issue_handle_i  in  1  parallel RAW/WAW hazard detected on current outputs
- nop_i  in  1  from hazard check: 1 = ls slot was nulled, 0 = bra slot was nulled
- instr_bra_int_o  out  XLEN  branch/int slot instruction (registered)
- instr_ls_int_o  out  XLEN  load-store/int slot instruction (registered)
- pc_bra_o  out  XLEN  PC of bra slot
- pc_ls_o  out  XLEN  PC of ls slot
- prio_iss_o  out  1  0 = bra slot older, 1 = ls slot older

Behaviour:
- Classify each instruction by opcode[6:0]:
  - MEM: 0000011 or 0100011.
  - BR: 1100011, 1101111 or 1100111.
  - INT: anything else.
  - An instruction equal to NOP_INSTR is an empty slot.
- Steering on accept (new pair registered next cycle):
  - INT+INT: instr0→bra, instr1→ls, prio=0.
  - MEM+INT: MEM→ls, INT→bra; BR+INT: BR→bra, INT→ls.
  - MEM+BR, either order: natural slots.
  - prio_iss_o points at the slot holding instr0.
- Structural split (MEM+MEM or BR+BR):
  - instr0 goes to its slot, other slot = NOP, prio = instr0's slot.
  - instr1 and its PC are stored in pend_q; pend_v_q=1.
  - Next cycle pend goes to its slot, other = NOP, prio = that slot, pend_v_q=0.
- Hazard replay: when stall_issue_handle_i=1 at a clock edge, outputs are rewritten:
  - nop_i=1 (ls deferred): instr_bra_int_o←NOP, instr_ls_int_o held, prio←1.
  - nop_i=0: instr_ls_int_o←NOP, instr_bra_int_o held, prio←0.
  - PCs held. One replay cycle only.
- fetch_ready_o = !rst_i && !flush_i && !stall_issue_handle_i && !pend_v_q (combinational).
- No valid pair and no pending work → both slots NOP, prio 0.
- Precedence per edge: rst_i > flush_i > stall replay > pending drain > new accept.
  - If stall and pend_v_q coincide, the replay is applied and pend is kept for the following cycle.
- flush_i: both slots NOP, PCs 0, prio 0, pend_v_q=0; pair offered that cycle is not accepted.
- Reset values:
  - instr_bra_int_o/instr_ls_int_o = NOP_INSTR.
  - pc_bra_o/pc_ls_o = 0, prio_iss_o = 0, pend_v_q = 0.
  - fetch_ready_o = 0 while rst_i=1.
  - Reset mid-split discards pend.
- Latency:
  - Accepted pair appears on outputs 1 cycle later.
  - Split pair completes in 2 cycles; hazard adds 1 cycle.

Optional Feature:
- Macro ISSUE_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_dual_o, perf_single_o, perf_stall_o (32-bit each, reset 0, wrap on overflow).
  - perf_dual_o counts cycles with two non-NOP slots.
  - perf_single_o counts cycles with exactly one non-NOP slot.
  - perf_stall_o counts cycles with stall_issue_handle_i=1.
- When undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Pair add x1,x2,x3 (0x003100B3) + lw x5,0(x6) (0x00032283), pc 0x100, valid → next cycle: bra=0x003100B3, ls=0x00032283, pc_bra=0x100, pc_ls=0x104, prio=0, ready stays 1.
- Pair lw x5,0(x6) + lw x7,4(x6) → cycle1: ls=0x00032283, bra=NOP, prio=1, ready=0; cycle2: ls=0x00432383, bra=NOP, pc_ls=pc+4; cycle3: ready=1.
- INT+INT pair, stall_issue_handle_i=1 with nop_i=1 for one cycle → next: bra=NOP, ls held, prio=1, ready low during stall cycle only.
- flush_i=1 while pend_v_q=1 → next cycle both slots NOP, pend dropped, ready=1; no younger instruction ever appears.
- Assert rst_i mid-split, then release → outputs NOP/0/0; first pair after release issues normally in 1 cycle.
- With ISSUE_PERF_CNT_EN: 3 dual pairs + 1 split pair → perf_dual_o=3, perf_single_o=2, perf_stall_o=0.

Source files
------------

// File: rtl/issue_slot_steer.sv
// Issue-stage register that steers an in-order fetch pair into the
// branch/int and load-store/int slots. Structurally conflicting pairs
// (two memory ops or two control-flow ops) are split over two cycles, and
// a stall from the parallel hazard check replays the current outputs with
// the deferred slot nulled.
// Optional build macro: ISSUE_PERF_CNT_EN adds slot-occupancy and stall
// performance counters.
module issue_slot_steer #(
   parameter int unsigned      XLEN      = 32,
   parameter logic [XLEN-1:0]  NOP_INSTR = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            fetch_valid_i,
   input  logic [XLEN-1:0] fetch_instr0_i,
   input  logic [XLEN-1:0] fetch_instr1_i,
   input  logic [XLEN-1:0] fetch_pc_i,
   output logic            fetch_ready_o,
   input  logic            flush_i,
   input  logic            stall_issue_handle_i,
   input  logic            nop_i,
   output logic [XLEN-1:0] instr_bra_int_o,
   output logic [XLEN-1:0] instr_ls_int_o,
   output logic [XLEN-1:0] pc_bra_o,
   output logic [XLEN-1:0] pc_ls_o,
   output logic            prio_iss_o
`ifdef ISSUE_PERF_CNT_EN
   ,
   output logic [31:0]     perf_dual_o,
   output logic [31:0]     perf_single_o,
   output logic [31:0]     perf_stall_o
`endif
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [XLEN-1:0] instr_bra_q, instr_bra_d;
   logic [XLEN-1:0] instr_ls_q,  instr_ls_d;
   logic [XLEN-1:0] pc_bra_q,    pc_bra_d;
   logic [XLEN-1:0] pc_ls_q,     pc_ls_d;
   logic            prio_q,      prio_d;
   logic [XLEN-1:0] pend_instr_q, pend_instr_d;
   logic [XLEN-1:0] pend_pc_q,    pend_pc_d;
   logic            pend_v_q,     pend_v_d;

   logic [6:0]      op0, op1, op_pend;
   logic            mem0, mem1, br0, br1, empty0, empty1, mem_pend;
   logic            split, i0_to_ls;
   logic [XLEN-1:0] pc1;

   assign op0      = fetch_instr0_i[6:0];
   assign op1      = fetch_instr1_i[6:0];
   assign op_pend  = pend_instr_q[6:0];
   assign mem0     = (op0 == OP_LOAD) || (op0 == OP_STORE);
   assign mem1     = (op1 == OP_LOAD) || (op1 == OP_STORE);
   assign br0      = (op0 == OP_BRANCH) || (op0 == OP_JAL) || (op0 == OP_JALR);
   assign br1      = (op1 == OP_BRANCH) || (op1 == OP_JAL) || (op1 == OP_JALR);
   assign mem_pend = (op_pend == OP_LOAD) || (op_pend == OP_STORE);
   assign empty0   = (fetch_instr0_i == NOP_INSTR);
   assign empty1   = (fetch_instr1_i == NOP_INSTR);
   assign pc1      = fetch_pc_i + XLEN'(4);

   // An empty slot never conflicts, so a lone instruction is never split.
   assign split    = !empty0 && !empty1 && ((mem0 && mem1) || (br0 && br1));
   // instr0 lands in ls when it is a memory op, or when an INT is paired
   // with a younger control-flow op that needs the bra slot.
   assign i0_to_ls = mem0 || (!br0 && br1 && !empty1);

   assign fetch_ready_o = !rst_i && !flush_i && !stall_issue_handle_i && !pend_v_q;

   // Next-state selection: flush > stall replay > pending drain > accept > idle.
   always_comb begin
      instr_bra_d  = instr_bra_q;
      instr_ls_d   = instr_ls_q;
      pc_bra_d     = pc_bra_q;
      pc_ls_d      = pc_ls_q;
      prio_d       = prio_q;
      pend_instr_d = pend_instr_q;
      pend_pc_d    = pend_pc_q;
      pend_v_d     = pend_v_q;
      if (flush_i) begin
         instr_bra_d = NOP_INSTR;
         instr_ls_d  = NOP_INSTR;
         pc_bra_d    = '0;
         pc_ls_d     = '0;
         prio_d      = 1'b0;
         pend_v_d    = 1'b0;
      end else if (stall_issue_handle_i) begin
         // Pending half of a split is kept and drains after the replay.
         if (nop_i) begin
            instr_bra_d = NOP_INSTR;
            prio_d      = 1'b1;
         end else begin
            instr_ls_d  = NOP_INSTR;
            prio_d      = 1'b0;
         end
      end else if (pend_v_q) begin
         pend_v_d = 1'b0;
         if (mem_pend) begin
            instr_ls_d  = pend_instr_q;
            pc_ls_d     = pend_pc_q;
            instr_bra_d = NOP_INSTR;
            prio_d      = 1'b1;
         end else begin
            instr_bra_d = pend_instr_q;
            pc_bra_d    = pend_pc_q;
            instr_ls_d  = NOP_INSTR;
            prio_d      = 1'b0;
         end
      end else if (fetch_valid_i) begin
         if (split) begin
            pend_instr_d = fetch_instr1_i;
            pend_pc_d    = pc1;
            pend_v_d     = 1'b1;
            if (mem0) begin
               instr_ls_d  = fetch_instr0_i;
               pc_ls_d     = fetch_pc_i;
               instr_bra_d = NOP_INSTR;
               prio_d      = 1'b1;
            end else begin
               instr_bra_d = fetch_instr0_i;
               pc_bra_d    = fetch_pc_i;
               instr_ls_d  = NOP_INSTR;
               prio_d      = 1'b0;
            end
         end else if (i0_to_ls) begin
            instr_ls_d  = fetch_instr0_i;
            pc_ls_d     = fetch_pc_i;
            instr_bra_d = fetch_instr1_i;
            pc_bra_d    = pc1;
            prio_d      = 1'b1;
         end else begin
            instr_bra_d = fetch_instr0_i;
            pc_bra_d    = fetch_pc_i;
            instr_ls_d  = fetch_instr1_i;
            pc_ls_d     = pc1;
            prio_d      = 1'b0;
         end
      end else begin
         instr_bra_d = NOP_INSTR;
         instr_ls_d  = NOP_INSTR;
         prio_d      = 1'b0;
      end
   end

   // Slot and pending registers; reset discards any half-issued split.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instr_bra_q  <= NOP_INSTR;
         instr_ls_q   <= NOP_INSTR;
         pc_bra_q     <= '0;
         pc_ls_q      <= '0;
         prio_q       <= 1'b0;
         pend_instr_q <= NOP_INSTR;
         pend_pc_q    <= '0;
         pend_v_q     <= 1'b0;
      end else begin
         instr_bra_q  <= instr_bra_d;
         instr_ls_q   <= instr_ls_d;
         pc_bra_q     <= pc_bra_d;
         pc_ls_q      <= pc_ls_d;
         prio_q       <= prio_d;
         pend_instr_q <= pend_instr_d;
         pend_pc_q    <= pend_pc_d;
         pend_v_q     <= pend_v_d;
      end
   end

   assign instr_bra_int_o = instr_bra_q;
   assign instr_ls_int_o  = instr_ls_q;
   assign pc_bra_o        = pc_bra_q;
   assign pc_ls_o         = pc_ls_q;
   assign prio_iss_o      = prio_q;

`ifdef ISSUE_PERF_CNT_EN
   logic [31:0] perf_dual_q, perf_single_q, perf_stall_q;
   logic        bra_busy, ls_busy;

   assign bra_busy = (instr_bra_q != NOP_INSTR);
   assign ls_busy  = (instr_ls_q  != NOP_INSTR);

   // Occupancy counters sample the slots currently presented downstream.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_dual_q   <= '0;
         perf_single_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (bra_busy && ls_busy) perf_dual_q   <= perf_dual_q + 32'd1;
         if (bra_busy ^ ls_busy)  perf_single_q <= perf_single_q + 32'd1;
         if (stall_issue_handle_i) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_dual_o   = perf_dual_q;
   assign perf_single_o = perf_single_q;
   assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_issue_slot_steer.sv
// Directed bench for issue_slot_steer: steering patterns, split pairs,
// hazard replay, flush and reset interaction, optional perf counters.
module tb_issue_slot_steer;

   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] ADD  = 32'h0031_00B3;
   localparam logic [31:0] ADDI = 32'h0010_8093;
   localparam logic [31:0] LW0  = 32'h0003_2283;
   localparam logic [31:0] LW1  = 32'h0043_2383;
   localparam logic [31:0] SW   = 32'h0053_2023;
   localparam logic [31:0] BEQ  = 32'h0000_0063;
   localparam logic [31:0] JAL  = 32'h0000_006F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [31:0] i0 = '0, i1 = '0, pc = '0;
   logic        ready, flush = 1'b0, stall = 1'b0, nop = 1'b0;
   logic [31:0] bra, ls, pc_bra, pc_ls;
   logic        prio;
`ifdef ISSUE_PERF_CNT_EN
   logic [31:0] perf_dual, perf_single, perf_stall;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   issue_slot_steer dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .fetch_valid_i        (valid),
      .fetch_instr0_i       (i0),
      .fetch_instr1_i       (i1),
      .fetch_pc_i           (pc),
      .fetch_ready_o        (ready),
      .flush_i              (flush),
      .stall_issue_handle_i (stall),
      .nop_i                (nop),
      .instr_bra_int_o      (bra),
      .instr_ls_int_o       (ls),
      .pc_bra_o             (pc_bra),
      .pc_ls_o              (pc_ls),
      .prio_iss_o           (prio)
`ifdef ISSUE_PERF_CNT_EN
      ,
      .perf_dual_o          (perf_dual),
      .perf_single_o        (perf_single),
      .perf_stall_o         (perf_stall)
`endif
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p);
      valid = v; i0 = a; i1 = b; pc = p;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      @(negedge clk);
      total_cnt++; if (bra !== NOP) $display("FAIL reset_bra got %h exp %h", bra, NOP); else pass_cnt++;
      total_cnt++; if (ls !== NOP) $display("FAIL reset_ls got %h exp %h", ls, NOP); else pass_cnt++;
      total_cnt++; if (pc_bra !== 32'h0 || pc_ls !== 32'h0) $display("FAIL reset_pc got %h/%h exp 0/0", pc_bra, pc_ls); else pass_cnt++;
      total_cnt++; if (prio !== 1'b0) $display("FAIL reset_prio got %b exp 0", prio); else pass_cnt++;
      total_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready); else pass_cnt++;
      cyc(); rst = 1'b0;
      @(negedge clk);
      total_cnt++; if (ready !== 1'b1) $display("FAIL release_ready got %b exp 1", ready); else pass_cnt++;
   endtask

   task automatic test_dual();
      cyc(); drive(1'b1, ADD, LW0, 32'h100);
      @(negedge clk);
      total_cnt++; if (ready !== 1'b1) $display("FAIL dual_ready_in got %b exp 1", ready); else pass_cnt++;
      cyc(); drive(1'b0, NOP, NOP, 32'h0);
      @(negedge clk);
      total_cnt++; if (bra !== ADD || ls !== LW0) $display("FAIL dual_slots got %h/%h exp %h/%h", bra, ls, ADD, LW0); else pass_cnt++;
      total_cnt++; if (pc_bra !== 32'h100 || pc_ls !== 32'h104) $display("FAIL dual_pc got %h/%h exp 100/104", pc_bra, pc_ls); else pass_cnt++;
      total_cnt++; if (prio !== 1'b0) $display("FAIL dual_prio got %b exp 0", prio); else pass_cnt++;
      total_cnt++; if (ready !== 1'b1) $display("FAIL dual_ready got %b exp 1", ready); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      cyc(); drive(1'b1, ADD, JAL, 32'h140);
      cyc(); drive(1'b1, SW, BEQ, 32'h180);
      @(negedge clk);
      total_cnt++; if (bra !== JAL || ls !== ADD) $display("FAIL int_br_slots got %h/%h exp %h/%h", bra, ls, JAL, ADD); else pass_cnt++;
      total_cnt++; if (pc_bra !== 32'h144 || pc_ls !== 32'h140) $display("FAIL int_br_pc got %h/%h exp 144/140", pc_bra, pc_ls); else pass_cnt++;
      total_cnt++; if (prio !== 1'b1) $display("FAIL int_br_prio got %b exp 1", prio); else pass_cnt++;
      cyc(); drive(1'b0, NOP, NOP, 32'h0);
      @(negedge clk);
      total_cnt++; if (bra !== BEQ || ls !== SW) $display("FAIL mem_br_slots got %h/%h exp %h/%h", bra, ls, BEQ, SW); else pass_cnt++;
      total_cnt++; if (pc_bra !== 32'h184 || pc_ls !== 32'h180 || prio !== 1'b1) $display("FAIL mem_br_pc_prio got %h/%h/%b exp 184/180/1", pc_bra, pc_ls, prio); else pass_cnt++;
      cyc();
      @(negedge clk);
      total_cnt++; if (bra !== NOP || ls !== NOP || prio !== 1'b0) $display("FAIL idle got %h/%h/%b exp NOP/NOP/0", bra, ls, prio); else pass_cnt++;
   endtask

   task automatic test_split();
      cyc(); drive(1'b1, LW0, LW1, 32'h200);
      cyc(); drive(1'b0, NOP, NOP, 32'h0);
      @(negedge clk);
      total_cnt++; if (ls !== LW0 || bra !== NOP) $display("FAIL split1_slots got %h/%h exp %h/%h", bra, ls, NOP, LW0); else pass_cnt++;
      total_cnt++; if (prio !== 1'b1 || pc_ls !== 32'h200) $display("FAIL split1_prio_pc got %b/%h exp 1/200", prio, pc_ls); else pass_cnt++;
      total_cnt++; if (ready !== 1'b0) $display("FAIL split1_ready got %b exp 0", ready); else pass_cnt++;
      cyc();
      @(negedge clk);
      total_cnt++; if (ls !== LW1 || bra !== NOP) $display("FAIL split2_slots got %h/%h exp %h/%h", bra, ls, NOP, LW1); else pass_cnt++;
      total_cnt++; if (pc_ls !== 32'h204 || prio !== 1'b1) $display("FAIL split2_pc_prio got %h/%b exp 204/1", pc_ls, prio); else pass_cnt++;
      total_cnt++; if (ready !== 1'b1) $display("FAIL split2_ready got %b exp 1", ready); else pass_cnt++;
   endtask

   task automatic test_stall();
      cyc(); drive(1'b1, ADD, ADDI, 32'h300);
      cyc(); drive(1'b0, NOP, NOP, 32'h0); stall = 1'b1; nop = 1'b1;
      @(negedge clk);
      total_cnt++; if (ready !== 1'b0) $display("FAIL stall_ready got %b exp 0", ready); else pass_cnt++;
      cyc(); stall = 1'b0; nop = 1'b0;
      @(negedge clk);
      total_cnt++; if (bra !== NOP || ls !== ADDI) $display("FAIL replay_ls_slots got %h/%h exp %h/%h", bra, ls, NOP, ADDI); else pass_cnt++;
      total_cnt++; if (prio !== 1'b1) $display("FAIL replay_ls_prio got %b exp 1", prio); else pass_cnt++;
      total_cnt++; if (pc_bra !== 32'h300 || pc_ls !== 32'h304) $display("FAIL replay_pc got %h/%h exp 300/304", pc_bra, pc_ls); else pass_cnt++;
      total_cnt++; if (ready !== 1'b1) $display("FAIL replay_ready got %b exp 1", ready); else pass_cnt++;
      cyc(); drive(1'b1, ADD, JAL, 32'h340);
      cyc(); drive(1'b0, NOP, NOP, 32'h0); stall = 1'b1; nop = 1'b0;
      cyc(); stall = 1'b0;
      @(negedge clk);
      total_cnt++; if (bra !== JAL || ls !== NOP) $display("FAIL replay_bra_slots got %h/%h exp %h/%h", bra, ls, JAL, NOP); else pass_cnt++;
      total_cnt++; if (prio !== 1'b0) $display("FAIL replay_bra_prio got %b exp 0", prio); else pass_cnt++;
   endtask

   task automatic test_stall_pend();
      cyc(); drive(1'b1, BEQ, JAL, 32'h500);
      cyc(); drive(1'b0, NOP, NOP, 32'h0); stall = 1'b1; nop = 1'b0;
      @(negedge clk);
      total_cnt++; if (bra !== BEQ || ls !== NOP || prio !== 1'b0) $display("FAIL brsplit1 got %h/%h/%b exp %h/%h/0", bra, ls, prio, BEQ, NOP); else pass_cnt++;
      cyc(); stall = 1'b0;
      @(negedge clk);
      total_cnt++; if (bra !== BEQ || ls !== NOP) $display("FAIL stall_pend_hold got %h/%h exp %h/%h", bra, ls, BEQ, NOP); else pass_cnt++;
      total_cnt++; if (ready !== 1'b0) $display("FAIL stall_pend_ready got %b exp 0", ready); else pass_cnt++;
      cyc();
      @(negedge clk);
      total_cnt++; if (bra !== JAL || pc_bra !== 32'h504 || ls !== NOP) $display("FAIL stall_pend_drain got %h/%h/%h exp %h/504/%h", bra, pc_bra, ls, JAL, NOP); else pass_cnt++;
   endtask

   task automatic test_flush_pend();
      cyc(); drive(1'b1, LW0, LW1, 32'h400);
      cyc(); drive(1'b1, ADD, ADDI, 32'h480); flush = 1'b1;
      @(negedge clk);
      total_cnt++; if (ready !== 1'b0) $display("FAIL flush_ready got %b exp 0", ready); else pass_cnt++;
      cyc(); drive(1'b0, NOP, NOP, 32'h0); flush = 1'b0;
      @(negedge clk);
      total_cnt++; if (bra !== NOP || ls !== NOP) $display("FAIL flush_slots got %h/%h exp NOP/NOP", bra, ls); else pass_cnt++;
      total_cnt++; if (pc_bra !== 32'h0 || pc_ls !== 32'h0 || prio !== 1'b0) $display("FAIL flush_pc_prio got %h/%h/%b exp 0/0/0", pc_bra, pc_ls, prio); else pass_cnt++;
      total_cnt++; if (ready !== 1'b1) $display("FAIL flush_drop_ready got %b exp 1", ready); else pass_cnt++;
      cyc();
      @(negedge clk);
      total_cnt++; if (ls !== NOP || bra !== NOP) $display("FAIL flush_no_younger got %h/%h exp NOP/NOP", bra, ls); else pass_cnt++;
   endtask

   task automatic test_reset_mid_split();
      cyc(); drive(1'b1, LW0, LW1, 32'h600);
      cyc(); drive(1'b0, NOP, NOP, 32'h0); rst = 1'b1;
      cyc(); rst = 1'b0;
      @(negedge clk);
      total_cnt++; if (bra !== NOP || ls !== NOP || prio !== 1'b0 || pc_ls !== 32'h0) $display("FAIL rst_split_out got %h/%h/%b/%h exp NOP/NOP/0/0", bra, ls, prio, pc_ls); else pass_cnt++;
      total_cnt++; if (ready !== 1'b1) $display("FAIL rst_split_ready got %b exp 1", ready); else pass_cnt++;
      drive(1'b1, ADD, LW0, 32'h640);
      cyc(); drive(1'b0, NOP, NOP, 32'h0);
      @(negedge clk);
      total_cnt++; if (bra !== ADD || ls !== LW0 || pc_bra !== 32'h640 || pc_ls !== 32'h644) $display("FAIL rst_first_pair got %h/%h/%h/%h exp %h/%h/640/644", bra, ls, pc_bra, pc_ls, ADD, LW0); else pass_cnt++;
   endtask

`ifdef ISSUE_PERF_CNT_EN
   task automatic test_perf();
      cyc(); rst = 1'b1;
      cyc(); rst = 1'b0;
      drive(1'b1, ADD, LW0, 32'h700);
      cyc(); drive(1'b1, ADD, LW0, 32'h708);
      cyc(); drive(1'b1, ADD, LW0, 32'h710);
      cyc(); drive(1'b1, LW0, LW1, 32'h718);
      cyc(); drive(1'b0, NOP, NOP, 32'h0);
      repeat (4) cyc();
      @(negedge clk);
      total_cnt++; if (perf_dual !== 32'd3) $display("FAIL perf_dual got %0d exp 3", perf_dual); else pass_cnt++;
      total_cnt++; if (perf_single !== 32'd2) $display("FAIL perf_single got %0d exp 2", perf_single); else pass_cnt++;
      total_cnt++; if (perf_stall !== 32'd0) $display("FAIL perf_stall got %0d exp 0", perf_stall); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_dual();
      test_back_to_back();
      test_split();
      test_stall();
      test_stall_pend();
      test_flush_pend();
      test_reset_mid_split();
`ifdef ISSUE_PERF_CNT_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
